// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types for the D-cache request arbiter: request packets, priority modes and sizing constants.
package dcache_req_arbiter_pkg;

    localparam int unsigned N_PORTS      = 2;
    localparam int unsigned N_ST         = 4;
    localparam int unsigned N_LD         = 2;
    localparam int unsigned STARVE_LIMIT = 8;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LD_IDX_W   = (N_LD > 1) ? $clog2(N_LD) : 1;
    localparam int unsigned NUM_SENT_W = $clog2(N_ST + 1);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic [1:0] size;
        logic       is_signed;
    } mem_func_t;

    typedef struct packed {
        logic              valid;
        addr_t             addr;
        logic [DATA_W-1:0] data;
        mem_func_t         byte_info;
    } sq_dcache_packet_t;

    typedef struct packed {
        logic                valid;
        logic                is_store;
        addr_t               addr;
        logic [DATA_W-1:0]   data;
        mem_func_t           byte_info;
        logic [LD_IDX_W-1:0] ld_idx;
    } dc_req_packet_t;

    typedef enum logic [1:0] {
        LOAD_FIRST,
        STORE_FIRST,
        DRAIN
    } arb_mode_e;

    function automatic logic [NUM_SENT_W-1:0] popcount_st(input logic [N_ST-1:0] v);
        logic [NUM_SENT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_ST; i++) begin
            cnt = cnt + NUM_SENT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// Request/accept bundle between the store queue, load queue, arbiter and D-cache ports.
interface dcache_req_arbiter_if;
    import dcache_req_arbiter_pkg::*;

    sq_dcache_packet_t [N_ST-1:0]    sq_req;
    logic [N_ST-1:0]                 sq_accept;
    logic [NUM_SENT_W-1:0]           num_sent;
    logic                            sq_almost_full;
    logic [N_LD-1:0]                 lq_valid;
    addr_t [N_LD-1:0]                lq_addr;
    mem_func_t [N_LD-1:0]            lq_byte_info;
    logic [N_LD-1:0]                 lq_accept;
    dc_req_packet_t [N_PORTS-1:0]    dc_req;
    logic [N_PORTS-1:0]              dc_ready;
    arb_mode_e                       mode;

    // Arbiter side.
    modport master (
        input  sq_req, sq_almost_full, lq_valid, lq_addr, lq_byte_info, dc_ready,
        output sq_accept, num_sent, lq_accept, dc_req, mode
    );

    // Queue / cache side.
    modport slave (
        output sq_req, sq_almost_full, lq_valid, lq_addr, lq_byte_info, dc_ready,
        input  sq_accept, num_sent, lq_accept, dc_req, mode
    );

endinterface

// File: rtl/dcache_req_arbiter_port_alloc.sv
// Combinational slot allocator: walks an ordered request list and hands each valid request the
// lowest-numbered free slot not yet taken, until the slots run out.
module dcache_req_arbiter_port_alloc #(
    parameter int unsigned NReq     = 6,
    parameter int unsigned NPorts   = 2,
    parameter int unsigned PortIdxW = 1
) (
    input  logic [NPorts-1:0]               free_i,
    input  logic [NReq-1:0]                 req_i,
    output logic [NReq-1:0]                 gnt_o,
    output logic [NReq-1:0][PortIdxW-1:0]   slot_o
);

    logic [NPorts-1:0] taken;

    always_comb begin
        gnt_o  = '0;
        slot_o = '0;
        taken  = '0;
        for (int r = 0; r < NReq; r++) begin
            for (int p = 0; p < NPorts; p++) begin
                if (req_i[r] && !gnt_o[r] && free_i[p] && !taken[p]) begin
                    gnt_o[r]  = 1'b1;
                    slot_o[r] = PortIdxW'(p);
                    taken[p]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Arbitrates committed stores and load misses onto registered D-cache request slots, with
// load priority overridden by store starvation and store-queue pressure.
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = STARVE_LIMIT
) (
    input logic                   clock,
    input logic                   reset,
    dcache_req_arbiter_if.master  bus_io
);

    localparam int unsigned NReq     = N_LD + N_ST;
    localparam int unsigned CntW     = $clog2(StarveLimit + 1);
    localparam int unsigned PortIdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    arb_mode_e                     mode_q, mode_d;
    logic [CntW-1:0]               starve_cnt_q, starve_cnt_d;
    dc_req_packet_t [N_PORTS-1:0]  dc_req_q, dc_req_d;

    logic [N_PORTS-1:0]              free;
    logic [N_ST-1:0]                 st_req, st_gnt;
    logic [N_LD-1:0]                 ld_req, ld_gnt;
    logic [NReq-1:0]                 list_req, list_gnt;
    logic [NReq-1:0][PortIdxW-1:0]   list_slot;
    logic [N_ST-1:0][PortIdxW-1:0]   st_slot;
    logic [N_LD-1:0][PortIdxW-1:0]   ld_slot;

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            free[p] = !dc_req_q[p].valid || bus_io.dc_ready[p];
        end
        // Prefix-mask stores so a gap stops store granting.
        st_req    = '0;
        st_req[0] = bus_io.sq_req[0].valid;
        for (int i = 1; i < N_ST; i++) begin
            st_req[i] = bus_io.sq_req[i].valid && st_req[i-1];
        end
        ld_req = (mode_q == DRAIN) ? '0 : bus_io.lq_valid;
        if (!reset) begin
            st_req = '0;
            ld_req = '0;
        end
        list_req = (mode_q == LOAD_FIRST) ? {st_req, ld_req} : {ld_req, st_req};
    end

    dcache_req_arbiter_port_alloc #(
        .NReq     (NReq),
        .NPorts   (N_PORTS),
        .PortIdxW (PortIdxW)
    ) u_port_alloc (
        .free_i (free),
        .req_i  (list_req),
        .gnt_o  (list_gnt),
        .slot_o (list_slot)
    );

    always_comb begin
        if (mode_q == LOAD_FIRST) begin
            ld_gnt  = list_gnt[N_LD-1:0];
            st_gnt  = list_gnt[NReq-1:N_LD];
            ld_slot = list_slot[N_LD-1:0];
            st_slot = list_slot[NReq-1:N_LD];
        end else begin
            st_gnt  = list_gnt[N_ST-1:0];
            ld_gnt  = list_gnt[NReq-1:N_ST];
            st_slot = list_slot[N_ST-1:0];
            ld_slot = list_slot[NReq-1:N_ST];
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            dc_req_d[p] = dc_req_q[p];
            if (free[p]) dc_req_d[p].valid = 1'b0;
        end
        for (int i = 0; i < N_ST; i++) begin
            if (st_gnt[i]) begin
                dc_req_d[st_slot[i]] = '{valid: 1'b1, is_store: 1'b1,
                                         addr: bus_io.sq_req[i].addr,
                                         data: bus_io.sq_req[i].data,
                                         byte_info: bus_io.sq_req[i].byte_info,
                                         ld_idx: '0};
            end
        end
        for (int l = 0; l < N_LD; l++) begin
            if (ld_gnt[l]) begin
                dc_req_d[ld_slot[l]] = '{valid: 1'b1, is_store: 1'b0,
                                         addr: bus_io.lq_addr[l],
                                         data: '0,
                                         byte_info: bus_io.lq_byte_info[l],
                                         ld_idx: LD_IDX_W'(l)};
            end
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (mode_q == LOAD_FIRST && bus_io.sq_req[0].valid && !(|st_gnt)) begin
            starve_cnt_d = (starve_cnt_q == CntW'(StarveLimit)) ? starve_cnt_q
                                                                : starve_cnt_q + 1'b1;
        end

        mode_d = mode_q;
        if (bus_io.sq_almost_full) begin
            mode_d = DRAIN;
        end else begin
            unique case (mode_q)
                DRAIN:       if (!bus_io.sq_req[0].valid) mode_d = LOAD_FIRST;
                LOAD_FIRST:  if (starve_cnt_d == CntW'(StarveLimit)) mode_d = STORE_FIRST;
                STORE_FIRST: mode_d = LOAD_FIRST;
                default:     mode_d = LOAD_FIRST;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q       <= LOAD_FIRST;
            starve_cnt_q <= '0;
            dc_req_q     <= '0;
        end else begin
            mode_q       <= mode_d;
            starve_cnt_q <= starve_cnt_d;
            dc_req_q     <= dc_req_d;
        end
    end

    assign bus_io.sq_accept = st_gnt;
    assign bus_io.lq_accept = ld_gnt;
    assign bus_io.num_sent  = popcount_st(st_gnt);
    assign bus_io.dc_req    = dc_req_q;
    assign bus_io.mode      = mode_q;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter: reset, grant ordering, held slots, starvation and drain.
module tb_dcache_req_arbiter;
    import dcache_req_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_checks;
    int   n_fail;

    sq_dcache_packet_t st_pkt [N_ST];

    dcache_req_arbiter_if bus_if ();

    dcache_req_arbiter dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_sq(input logic [N_ST-1:0] mask);
        for (int i = 0; i < N_ST; i++) begin
            bus_if.sq_req[i]       = st_pkt[i];
            bus_if.sq_req[i].valid = mask[i];
        end
    endtask

    task automatic idle_inputs();
        set_sq('0);
        bus_if.sq_almost_full = 1'b0;
        bus_if.lq_valid       = '0;
        bus_if.dc_ready       = '0;
    endtask

    function automatic dc_req_packet_t exp_ld(input int idx);
        dc_req_packet_t e;
        e = '{valid: 1'b1, is_store: 1'b0, addr: bus_if.lq_addr[idx], data: '0,
              byte_info: bus_if.lq_byte_info[idx], ld_idx: LD_IDX_W'(idx)};
        return e;
    endfunction

    function automatic dc_req_packet_t exp_st(input int idx);
        dc_req_packet_t e;
        e = '{valid: 1'b1, is_store: 1'b1, addr: st_pkt[idx].addr, data: st_pkt[idx].data,
              byte_info: st_pkt[idx].byte_info, ld_idx: '0};
        return e;
    endfunction

    // Eight starved LOAD_FIRST cycles, then one STORE_FIRST cycle granting stores 0 and 1.
    task automatic starve_run(input string tag);
        for (int k = 1; k <= STARVE_LIMIT; k++) begin
            #2;
            check_eq({tag, "_mode_lf"}, bus_if.mode, LOAD_FIRST);
            check_eq({tag, "_sq_none"}, bus_if.sq_accept, 4'b0000);
            check_eq({tag, "_lq_both"}, bus_if.lq_accept, 2'b11);
            step();
        end
        #2;
        check_eq({tag, "_mode_sf"}, bus_if.mode, STORE_FIRST);
        check_eq({tag, "_sf_sq"}, bus_if.sq_accept, 4'b0011);
        check_eq({tag, "_sf_lq"}, bus_if.lq_accept, 2'b00);
        check_eq({tag, "_sf_sent"}, bus_if.num_sent, 3'd2);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < N_ST; i++) begin
            st_pkt[i] = '{valid: 1'b0, addr: addr_t'(32'h1000 + 16 * i),
                          data: 32'hd000_0000 + 32'(i), byte_info: '{size: 2'(i), is_signed: 1'b0}};
        end
        bus_if.lq_addr[0]      = 32'h2000;
        bus_if.lq_addr[1]      = 32'h2040;
        bus_if.lq_byte_info[0] = '{size: 2'd2, is_signed: 1'b1};
        bus_if.lq_byte_info[1] = '{size: 2'd1, is_signed: 1'b0};

        // Reset held with requests present: nothing accepted.
        reset = 1'b0;
        idle_inputs();
        bus_if.lq_valid = 2'b11;
        bus_if.dc_ready = 2'b11;
        set_sq(4'b0011);
        step();
        step();
        check_eq("rst_valid", {bus_if.dc_req[1].valid, bus_if.dc_req[0].valid}, 2'b00);
        check_eq("rst_mode", bus_if.mode, LOAD_FIRST);
        check_eq("rst_sq_acc", bus_if.sq_accept, 4'b0000);
        check_eq("rst_lq_acc", bus_if.lq_accept, 2'b00);
        check_eq("rst_sent", bus_if.num_sent, 3'd0);

        reset = 1'b1;
        idle_inputs();
        step();
        check_eq("post_rst_valid", {bus_if.dc_req[1].valid, bus_if.dc_req[0].valid}, 2'b00);
        check_eq("post_rst_mode", bus_if.mode, LOAD_FIRST);

        // Loads beat stores in LOAD_FIRST.
        bus_if.lq_valid = 2'b11;
        bus_if.dc_ready = 2'b11;
        set_sq(4'b0011);
        #2;
        check_eq("lf_lq_acc", bus_if.lq_accept, 2'b11);
        check_eq("lf_sq_acc", bus_if.sq_accept, 4'b0000);
        check_eq("lf_sent", bus_if.num_sent, 3'd0);
        step();
        check_eq("lf_slot0", bus_if.dc_req[0], exp_ld(0));
        check_eq("lf_slot1", bus_if.dc_req[1], exp_ld(1));

        // Slot 0 held, slot 1 completes and takes store 0.
        bus_if.lq_valid = 2'b00;
        bus_if.dc_ready = 2'b10;
        set_sq(4'b1111);
        #2;
        check_eq("held_sq_acc", bus_if.sq_accept, 4'b0001);
        check_eq("held_sent", bus_if.num_sent, 3'd1);
        check_eq("held_lq_acc", bus_if.lq_accept, 2'b00);
        step();
        check_eq("held_slot0", bus_if.dc_req[0], exp_ld(0));
        check_eq("held_slot1", bus_if.dc_req[1], exp_st(0));

        // Gap at store 1 stops the prefix; full window fills both slots.
        bus_if.dc_ready = 2'b11;
        set_sq(4'b1101);
        #2;
        check_eq("gap_sq_acc", bus_if.sq_accept, 4'b0001);
        check_eq("gap_sent", bus_if.num_sent, 3'd1);
        set_sq(4'b1111);
        #1;
        check_eq("two_sq_acc", bus_if.sq_accept, 4'b0011);
        check_eq("two_sent", bus_if.num_sent, 3'd2);
        step();
        check_eq("two_slot0", bus_if.dc_req[0], exp_st(0));
        check_eq("two_slot1", bus_if.dc_req[1], exp_st(1));

        // No free slot: nothing accepted.
        bus_if.dc_ready = 2'b00;
        bus_if.lq_valid = 2'b11;
        #1;
        check_eq("full_sq_acc", bus_if.sq_accept, 4'b0000);
        check_eq("full_lq_acc", bus_if.lq_accept, 2'b00);

        // Asynchronous reset with both slots held.
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_rst_valid", {bus_if.dc_req[1].valid, bus_if.dc_req[0].valid}, 2'b00);
        check_eq("async_rst_lq", bus_if.lq_accept, 2'b00);
        check_eq("async_rst_sq", bus_if.sq_accept, 4'b0000);
        step();
        reset = 1'b1;
        idle_inputs();

        // Starvation: two back-to-back runs show the counter restarts after STORE_FIRST.
        bus_if.lq_valid = 2'b11;
        bus_if.dc_ready = 2'b11;
        set_sq(4'b1111);
        starve_run("starve1");
        starve_run("starve2");

        // Store-queue pressure forces DRAIN until stores are gone.
        bus_if.sq_almost_full = 1'b1;
        step();
        #2;
        check_eq("drain_mode", bus_if.mode, DRAIN);
        check_eq("drain_lq", bus_if.lq_accept, 2'b00);
        check_eq("drain_sq", bus_if.sq_accept, 4'b0011);
        bus_if.sq_almost_full = 1'b0;
        step();
        #2;
        check_eq("drain_hold", bus_if.mode, DRAIN);
        set_sq(4'b0000);
        step();
        #2;
        check_eq("drain_exit", bus_if.mode, LOAD_FIRST);
        check_eq("drain_exit_lq", bus_if.lq_accept, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
